// File: rtl/parking_pkg.sv
// parking_pkg: shared lane-state type, vacancy width default and car-type encoding
package parking_pkg;
    typedef enum logic {IDLE = 1'b0, OPEN = 1'b1} lane_t;
    localparam int   CNT_W_DFLT = 11;
    localparam logic CAR_GEN    = 1'b0;
    localparam logic CAR_UNI    = 1'b1;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer + debouncer with a one-cycle rising-edge event
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : asynchronous sensor input
//   rise       : one-cycle pulse, the cycle after the debounced level goes high
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);
    logic       s1, s2, level;
    logic [3:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level)
                cnt <= '0;
            else if (cnt == 4'(DEBOUNCE_CYCLES - 1)) begin
                // this differing sample completes the run: accept the new level
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
            end else
                cnt <= cnt + 4'd1;
        end
endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit barrier controller producing Parking count events
//   clk, rst_n                    : clock, asynchronous active-low reset
//   ent_car_i/ent_uni_i/ent_pass_i: entry loop, card type, pass beam (raw)
//   ext_car_i/ext_uni_i/ext_pass_i: exit loop, card type, pass beam (raw)
//   vs, uvs                       : general / university vacancy from Parking
//   ci, uci, ce, uce              : one-cycle entry / exit count events
//   ent_gate_o, ext_gate_o        : barrier open commands
//   deny_o                        : one-cycle pulse on entry refused for lack of space
//   PARKING_GATE_TIMEOUT_EN       : when defined, an open barrier closes after OPEN_CYCLES
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPEN_CYCLES     = 20,
    parameter int CNT_W           = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ent_car_i,
    input  logic             ent_uni_i,
    input  logic             ent_pass_i,
    input  logic             ext_car_i,
    input  logic             ext_uni_i,
    input  logic             ext_pass_i,
    input  logic [CNT_W-1:0] vs,
    input  logic [CNT_W-1:0] uvs,
    output logic             ci,
    output logic             uci,
    output logic             ce,
    output logic             uce,
    output logic             ent_gate_o,
    output logic             ext_gate_o,
    output logic             deny_o
);
    localparam logic [0:0] E_IDLE = IDLE;
    localparam logic [0:0] E_OPEN = OPEN;
    localparam logic [0:0] X_IDLE = IDLE;
    localparam logic [0:0] X_OPEN = OPEN;

    logic       ent_arr, ent_pass, ext_arr, ext_pass;
    logic [0:0] e_st, x_st;
    logic       e_uni, x_uni, e_to, x_to, ent_full;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent_car  (.clk(clk), .rst_n(rst_n), .raw(ent_car_i),  .rise(ent_arr));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ent_pass (.clk(clk), .rst_n(rst_n), .raw(ent_pass_i), .rise(ent_pass));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext_car  (.clk(clk), .rst_n(rst_n), .raw(ext_car_i),  .rise(ext_arr));
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ext_pass (.clk(clk), .rst_n(rst_n), .raw(ext_pass_i), .rise(ext_pass));

    // vacancy is looked at only in the arrival-event cycle, with the live card type
    assign ent_full = (ent_uni_i == CAR_UNI) ? (uvs == '0) : (vs == '0);

`ifdef PARKING_GATE_TIMEOUT_EN
    localparam int TW = $clog2(OPEN_CYCLES + 1);
    logic [TW-1:0] e_tmr, x_tmr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_tmr <= '0;
            x_tmr <= '0;
        end else begin
            e_tmr <= (e_st == E_OPEN) ? e_tmr - TW'(e_tmr != '0) : (ent_arr && !ent_full) ? TW'(OPEN_CYCLES) : '0;
            x_tmr <= (x_st == X_OPEN) ? x_tmr - TW'(x_tmr != '0) : ext_arr ? TW'(OPEN_CYCLES) : '0;
        end
    // expiry is taken on the edge that would bring the timer to zero
    assign e_to = e_tmr <= TW'(1);
    assign x_to = x_tmr <= TW'(1);
`else
    localparam int unused_open_cycles = OPEN_CYCLES;
    assign e_to = 1'b0;
    assign x_to = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            e_st       <= E_IDLE;
            e_uni      <= CAR_GEN;
            ent_gate_o <= 1'b0;
            ci         <= 1'b0;
            uci        <= 1'b0;
            deny_o     <= 1'b0;
        end else begin
            ci     <= 1'b0;
            uci    <= 1'b0;
            deny_o <= 1'b0;
            if (e_st == E_IDLE) begin
                if (ent_arr) begin
                    e_uni <= ent_uni_i;
                    if (ent_full)
                        deny_o <= 1'b1;
                    else begin
                        e_st       <= E_OPEN;
                        ent_gate_o <= 1'b1;
                    end
                end
            end else if (ent_pass) begin
                // a pass wins over a simultaneous timeout
                ci         <= e_uni == CAR_GEN;
                uci        <= e_uni == CAR_UNI;
                e_st       <= E_IDLE;
                ent_gate_o <= 1'b0;
            end else if (e_to) begin
                e_st       <= E_IDLE;
                ent_gate_o <= 1'b0;
            end
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x_st       <= X_IDLE;
            x_uni      <= CAR_GEN;
            ext_gate_o <= 1'b0;
            ce         <= 1'b0;
            uce        <= 1'b0;
        end else begin
            ce  <= 1'b0;
            uce <= 1'b0;
            if (x_st == X_IDLE) begin
                if (ext_arr) begin
                    x_uni      <= ext_uni_i;
                    x_st       <= X_OPEN;
                    ext_gate_o <= 1'b1;
                end
            end else if (ext_pass) begin
                ce         <= x_uni == CAR_GEN;
                uce        <= x_uni == CAR_UNI;
                x_st       <= X_IDLE;
                ext_gate_o <= 1'b0;
            end else if (x_to) begin
                x_st       <= X_IDLE;
                ext_gate_o <= 1'b0;
            end
        end
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: directed scoreboard bench for parking_gate_ctrl
module tb_parking_gate_ctrl;
    localparam logic [6:0] DN  = 7'b1000000;
    localparam logic [6:0] EG  = 7'b0100000;
    localparam logic [6:0] XG  = 7'b0010000;
    localparam logic [6:0] CI  = 7'b0001000;
    localparam logic [6:0] UCI = 7'b0000100;
    localparam logic [6:0] CE  = 7'b0000010;
    localparam logic [6:0] UCE = 7'b0000001;
    localparam logic [6:0] ALL = 7'b1111111;

    typedef struct {
        int         cyc;
        string      tag;
        logic [6:0] exp;
        logic [6:0] msk;
    } chk_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        ent_car_i = 0, ent_uni_i = 0, ent_pass_i = 0;
    logic        ext_car_i = 0, ext_uni_i = 0, ext_pass_i = 0;
    logic [10:0] vs = 11'd5, uvs = 11'd3;
    logic        ci, uci, ce, uce, ent_gate_o, ext_gate_o, deny_o;
    logic [6:0]  obs;
    int          cyc = 0, n_cmp = 0, errs = 0;
    int          n_ci = 0, n_uci = 0, n_ce = 0, n_uce = 0, n_deny = 0;
    chk_t        q[$];

    parking_gate_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .ent_car_i(ent_car_i), .ent_uni_i(ent_uni_i), .ent_pass_i(ent_pass_i),
        .ext_car_i(ext_car_i), .ext_uni_i(ext_uni_i), .ext_pass_i(ext_pass_i),
        .vs(vs), .uvs(uvs),
        .ci(ci), .uci(uci), .ce(ce), .uce(uce),
        .ent_gate_o(ent_gate_o), .ext_gate_o(ext_gate_o), .deny_o(deny_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign obs = {deny_o, ent_gate_o, ext_gate_o, ci, uci, ce, uce};

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].cyc <= cyc) begin
                n_cmp++;
                assert ((obs & q[i].msk) === (q[i].exp & q[i].msk))
                else begin
                    errs++;
                    $error("FAIL %s cyc=%0d observed=%b expected=%b mask=%b", q[i].tag, cyc, obs & q[i].msk, q[i].exp & q[i].msk, q[i].msk);
                end
                q.delete(i);
            end
        n_ci   += int'(ci);
        n_uci  += int'(uci);
        n_ce   += int'(ce);
        n_uce  += int'(uce);
        n_deny += int'(deny_o);
    end

    task automatic chk(input int c, input string t, input logic [6:0] m, input logic [6:0] e);
        q.push_back('{c, t, e, m});
    endtask

    task automatic at(input int c);
        wait (cyc >= c);
        #1;
    endtask

    task automatic cmp_int(input string t, input int o, input int e);
        n_cmp++;
        assert (o == e)
        else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", t, o, e);
        end
    endtask

    initial begin
        chk(1, "reset_outputs", ALL, 7'b0);
        at(2);
        rst_n = 1'b1;

        // general entry: arrival at edge 10, pass at edge 30
        chk(15, "ent_gate_before_open", EG, 7'b0);
        chk(16, "ent_gate_open", EG | CI | UCI, EG);
        chk(35, "ci_before_pass", EG | CI, EG);
        chk(36, "ci_pulse", EG | CI | UCI, CI);
        chk(37, "ci_single_cycle", EG | CI | UCI, 7'b0);
        at(9);
        ent_car_i = 1; ent_uni_i = 0;
        at(29);
        ent_pass_i = 1;
        at(40);
        ent_car_i = 0; ent_pass_i = 0;

        // university entry with no university vacancy; later pass in idle is ignored
        chk(65, "deny_before", DN, 7'b0);
        chk(66, "deny_pulse", DN | EG | UCI, DN);
        chk(67, "deny_single_cycle", DN | EG | UCI, 7'b0);
        chk(76, "idle_pass_ignored", EG | CI | UCI, 7'b0);
        chk(77, "idle_pass_ignored2", EG | CI | UCI, 7'b0);
        at(59);
        uvs = 0; ent_uni_i = 1; ent_car_i = 1;
        at(69);
        ent_pass_i = 1;
        at(80);
        ent_car_i = 0; ent_pass_i = 0; ent_uni_i = 0; uvs = 3;

        // 3-cycle exit glitch, then a real university exit
        chk(96, "glitch_no_gate", XG | CE | UCE, 7'b0);
        chk(100, "glitch_no_gate2", XG | CE | UCE, 7'b0);
        chk(116, "ext_gate_open", XG, XG);
        chk(126, "uce_pulse", XG | CE | UCE, UCE);
        chk(127, "uce_single_cycle", XG | CE | UCE, 7'b0);
        at(89);
        ext_car_i = 1;
        at(92);
        ext_car_i = 0;
        at(109);
        ext_uni_i = 1; ext_car_i = 1;
        at(119);
        ext_pass_i = 1;
        at(130);
        ext_car_i = 0; ext_pass_i = 0; ext_uni_i = 0;

        // both lanes pass on the same edge
        chk(156, "both_gates_open", EG | XG, EG | XG);
        chk(166, "ci_ce_same_cycle", ALL, CI | CE);
        chk(167, "ci_ce_single_cycle", ALL, 7'b0);
        at(149);
        ent_car_i = 1; ext_car_i = 1;
        at(159);
        ent_pass_i = 1; ext_pass_i = 1;
        at(170);
        ent_car_i = 0; ext_car_i = 0; ent_pass_i = 0; ext_pass_i = 0;

        // arrival with no pass
        chk(206, "to_gate_open", EG, EG);
`ifdef PARKING_GATE_TIMEOUT_EN
        chk(225, "to_gate_still_open", EG | CI, EG);
        chk(226, "to_gate_closed", EG | CI | UCI, 7'b0);
        chk(300, "to_stays_closed", EG, 7'b0);
`else
        chk(226, "no_to_gate_open", EG, EG);
        chk(300, "no_to_gate_open_late", EG | CI, EG);
`endif
        at(199);
        ent_car_i = 1;
        at(310);
        ent_car_i = 0;

        // reset while the entry gate is open and a pass is in flight
        chk(336, "pre_reset_gate_open", EG, EG);
        chk(341, "in_reset_all_zero", ALL, 7'b0);
        chk(344, "no_ci_after_reset", CI | UCI, 7'b0);
        chk(348, "reopen_not_yet", EG, 7'b0);
        chk(349, "reopen_after_release", EG, EG);
        chk(366, "ci_after_reopen", EG | CI | UCI, CI);
        at(329);
        ent_car_i = 1;
        at(337);
        ent_pass_i = 1;
        at(340);
        rst_n = 1'b0;
        ent_pass_i = 0;
        #1;
        n_cmp++;
        assert (ent_gate_o === 1'b0 && ci === 1'b0)
        else begin
            errs++;
            $error("FAIL async_reset_gate observed=%b%b expected=00", ent_gate_o, ci);
        end
        at(342);
        rst_n = 1'b1;
        at(359);
        ent_pass_i = 1;
        at(370);
        ent_car_i = 0; ent_pass_i = 0;

        at(400);
        cmp_int("total_ci", n_ci, 3);
        cmp_int("total_uci", n_uci, 0);
        cmp_int("total_ce", n_ce, 1);
        cmp_int("total_uce", n_uce, 1);
        cmp_int("total_deny", n_deny, 1);
        cmp_int("checks_left", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, errs);
        $finish;
    end
endmodule

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Gate controller that sits directly upstream of the `Parking` occupancy counter.
- Debounces raw gate sensors and drives the entry and exit barriers.
- Produces the single-cycle `ci`/`uci`/`ce`/`uce` count events that `Parking` consumes.
- Uses `Parking`'s vacancy outputs (`vs`, `uvs`) to refuse entry when the relevant pool is full, so a car is counted only when it physically passes the barrier.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required to accept a sensor level change (range 1–15).
- `OPEN_CYCLES`, default 20: barrier-open timeout in cycles; used only with the timeout feature enabled.
- `CNT_W`, default 11: width of the vacancy inputs; matches `Parking`.

Ports:
- `clk` in, 1: single clock; all logic on the rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `ent_car_i` in, 1: raw entry-loop sensor; high while a car waits at the entry.
- `ent_uni_i` in, 1: entry card type (1 = university); sampled on the entry arrival event.
- `ent_pass_i` in, 1: raw entry pass-beam sensor.
- `ext_car_i` in, 1: raw exit-loop sensor.
- `ext_uni_i` in, 1: exit card type; sampled on the exit arrival event.
- `ext_pass_i` in, 1: raw exit pass-beam sensor.
- `vs` in, CNT_W: general vacancy from `Parking`.
- `uvs` in, CNT_W: university vacancy from `Parking`.
- `ci`, `uci` out, 1: one-cycle general / university entry events.
- `ce`, `uce` out, 1: one-cycle general / university exit events.
- `ent_gate_o`, `ext_gate_o` out, 1: barrier open commands.
- `deny_o` out, 1: one-cycle pulse when an entry is refused for lack of space.

## Operation
- **Input conditioning.** Each of the four raw sensors passes through a 2-flop synchronizer and then a debouncer.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive synchronized samples that differ from it.
  - Any matching sample clears the counter.
  - A rising edge of a debounced level is an *event* (arrival or pass).
- **Entry FSM** (`E_IDLE`, `E_OPEN`):
  - `E_IDLE`, on an entry arrival: latch `ent_uni_i`. If the selected vacancy (`uvs` when uni, else `vs`) is 0, pulse `deny_o` and stay in `E_IDLE`. Otherwise go to `E_OPEN`, assert `ent_gate_o` and load the timer with `OPEN_CYCLES`.
  - `E_OPEN`, on an entry pass event: pulse `uci` if the latched type is uni, else `ci`. Deassert the gate and return to `E_IDLE`.
  - Arrival events in `E_OPEN` are ignored. Pass events in `E_IDLE` are ignored and produce no pulse.
- **Exit FSM** (`X_IDLE`, `X_OPEN`): identical structure, with no vacancy check.
  - Exit arrival: latch `ext_uni_i` and open `ext_gate_o`.
  - Exit pass: pulse `uce` or `ce`, then close.
- The two lanes are fully independent. Entry and exit pulses may occur in the same cycle.
- At most one of `ci`/`uci` is high in any cycle; likewise at most one of `ce`/`uce`.

## Timing
- **Reset values:** all outputs 0, both FSMs idle, debounced levels 0, debounce counters and timers 0.
- **Arrival latency:** a raw high first sampled at edge k gives a debounced high after edge k+1+`DEBOUNCE_CYCLES`; the FSM reacts at the next edge. The gate opens after edge k+2+`DEBOUNCE_CYCLES` (k+6 with defaults).
- **Pass latency:** same as arrival. The count pulse is high for exactly the cycle after edge p+2+`DEBOUNCE_CYCLES`, and the gate closes at that same edge.
- **Deny:** `deny_o` uses the same latency as a gate open and lasts 1 cycle.
- **Vacancy sampling:** `vs`/`uvs` are sampled on the arrival-event cycle only. A later vacancy change does not revoke an open gate.
- **Reset mid-operation:** gates close and pulses drop asynchronously; no count pulse is emitted. A sensor still held high after reset release produces a fresh event after the normal latency.
- **Glitches:** a raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.

## Configuration
- **`PARKING_GATE_TIMEOUT_EN` defined:**
  - In `E_OPEN`/`X_OPEN` the timer decrements every cycle.
  - When the timer reaches 0 without a pass event, the gate closes, the FSM returns to idle and no count pulse is emitted.
  - A pass event and timer expiry in the same cycle resolve as a pass (pulse emitted).
- **Not defined:** no timer is synthesized, and the gate stays open until a pass event.

## Structure
- **Shared package `parking_pkg`:**
  - lane-state typedef (`IDLE`, `OPEN`)
  - `CNT_W` default constant
  - car-type encoding (`CAR_GEN` = 0, `CAR_UNI` = 1)
- **Sub-module `sensor_debounce`:** 2-flop synchronizer, debounce counter, debounced level and rising-edge event output. Instantiated 4 times.
- Each lane FSM is a generate-free, hand-written block in the top module.

## Test plan
Defaults apply: `DEBOUNCE_CYCLES`=4, `OPEN_CYCLES`=20.
- **General entry:** `vs`=5; raise `ent_car_i` at edge 10, `ent_uni_i`=0 → `ent_gate_o`=1 after edge 16. Raise `ent_pass_i` at edge 30 → `ci`=1 for the single cycle after edge 36 and the gate closes; `uci` stays 0.
- **University entry full:** `uvs`=0, `ent_uni_i`=1, arrival → one-cycle `deny_o`, gate never opens, no `uci`.
- **Glitch rejection:** a 3-cycle `ext_car_i` pulse → no gate, no events. Then `ext_uni_i`=1 with a held arrival plus pass → exactly one `uce`.
- **Simultaneous lanes:** entry and exit pass events on the same edge → `ci` and `ce` high in the same cycle, one cycle each.
- **Timeout (macro on):** arrival with no pass → gate closes 20 cycles after opening, no pulse. Same stimulus with the macro off → gate is still open at cycle 100.
- **Reset mid-open:** assert `rst_n`=0 while `ent_gate_o`=1 → gate 0 immediately and no pulse. With `ent_car_i` held high, the gate reopens 6 edges after release.
